// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b computed as a + ~b + 1 through one
// full-adder cell, one bit per clock, LSB first. Operands enter on a
// valid/ready port and the N+1 bit result leaves on a valid/ready port.
// Optional build macro SERIAL_ADD_MODE_EN adds an 'op' input (1 = add,
// 0 = subtract); without it the block only subtracts.
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef SERIAL_ADD_MODE_EN
    input  logic         op,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   result
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [N-1:0]   a_sr_r;
    logic [N-1:0]   b_sr_r;
    logic [N-1:0]   sum_sr_r;
    logic           carry_r;
    logic           add_r;
    logic [CW-1:0]  cnt_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [N:0]     result_r;

    logic           accept_s;
    logic           last_bit_s;
    logic           op_sel_s;
    logic           s_bit_s;
    logic           carry_next_s;
    logic           msb_s;
    logic [N-1:0]   sum_shift_s;

    // Three-input majority: carry out of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Three-input XOR: sum bit of a full adder.
    function automatic logic xor3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

`ifdef SERIAL_ADD_MODE_EN
    assign op_sel_s = op;
`else
    assign op_sel_s = 1'b0;
`endif

    // Next-state logic and the single full-adder cell with its shifted sum.
    always_comb begin
        state_next_s  = state_r;
        accept_s      = 1'b0;
        last_bit_s    = 1'b0;
        s_bit_s       = xor3(a_sr_r[0], b_sr_r[0], carry_r);
        carry_next_s  = maj3(a_sr_r[0], b_sr_r[0], carry_r);
        msb_s         = add_r ? carry_next_s : ~carry_next_s;
        sum_shift_s   = sum_sr_r >> 1'b1;
        sum_shift_s[N-1] = s_bit_s;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    last_bit_s   = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake outputs registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Operand capture, bit-serial shifting and final result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r   <= {N{1'b0}};
            b_sr_r   <= {N{1'b0}};
            sum_sr_r <= {N{1'b0}};
            carry_r  <= 1'b0;
            add_r    <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            result_r <= {(N+1){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        // Subtract feeds ~b with carry-in 1; add feeds b with carry-in 0.
                        a_sr_r   <= a;
                        b_sr_r   <= op_sel_s ? b : ~b;
                        carry_r  <= ~op_sel_s;
                        add_r    <= op_sel_s;
                        cnt_r    <= {CW{1'b0}};
                        sum_sr_r <= {N{1'b0}};
                    end else begin
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    a_sr_r   <= a_sr_r >> 1'b1;
                    b_sr_r   <= b_sr_r >> 1'b1;
                    carry_r  <= carry_next_s;
                    sum_sr_r <= sum_shift_s;
                    if (last_bit_s) begin
                        // Result only changes here, so it never shows a partial sum.
                        cnt_r    <= {CW{1'b0}};
                        result_r <= {msb_s, sum_shift_s};
                    end else begin
                        cnt_r    <= cnt_r + CW'(1'b1);
                    end
                end
                DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=4): a table of directed
// subtract vectors plus hand-written backpressure, simultaneous-handshake
// and mid-operation reset sequences.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   result;

    int checks;
    int errors;

    serial_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_MODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands and return #1 after the accepting edge.
    task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic opv);
        int guard;
        @(negedge clk);
        a = av;
        b = bv;
        op = opv;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid rises (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 4'd0;
        b         = 4'd0;
        op        = 1'b0;

        vecs[0] = '{"9-3",  4'd9,  4'd3,  5'b00110};
        vecs[1] = '{"3-9",  4'd3,  4'd9,  5'b11010};
        vecs[2] = '{"0-15", 4'd0,  4'd15, 5'b10001};
        vecs[3] = '{"7-7",  4'd7,  4'd7,  5'b00000};
        vecs[4] = '{"15-0", 4'd15, 4'd0,  5'b01111};
        vecs[5] = '{"8-1",  4'd8,  4'd1,  5'b00111};
        vecs[6] = '{"1-2",  4'd1,  4'd2,  5'b11111};
        vecs[7] = '{"12-5", 4'd12, 4'd5,  5'b00111};

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result",    {27'd0, result},    32'd0);

        // Table-driven subtract vectors, downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, 1'b0);
            check({vecs[i].name, "_busy"}, {31'd0, in_ready}, 32'd0);
            wait_valid(lat);
            check({vecs[i].name, "_latency"}, lat, 32'd4);
            check({vecs[i].name, "_result"}, {27'd0, result}, {27'd0, vecs[i].exp});
            @(posedge clk);
            #1;
            check({vecs[i].name, "_drained"}, {31'd0, out_valid}, 32'd0);
            check({vecs[i].name, "_idle"},    {31'd0, in_ready},  32'd1);
            check({vecs[i].name, "_held"},    {27'd0, result},    {27'd0, vecs[i].exp});
        end

        // Backpressure: result held for 10 cycles, in_valid pulses ignored.
        out_ready = 1'b0;
        send(4'd9, 4'd3, 1'b0);
        wait_valid(lat);
        check("bp_latency", lat, 32'd4);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = k[0];
            a = 4'd1;
            b = 4'd1;
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result",    {27'd0, result},    32'd6);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end

        // Accept result with new operands offered on the same edge.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 4'd5;
        b = 4'd2;
        @(posedge clk);
        #1;
        check("sim_out_valid", {31'd0, out_valid}, 32'd0);
        check("sim_not_taken", {31'd0, in_ready},  32'd1);
        check("sim_result",    {27'd0, result},    32'd6);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sim_taken_next", {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        check("sim_latency", lat, 32'd4);
        check("sim_new_result", {27'd0, result}, 32'd3);
        @(posedge clk);
        #1;

        // Reset after two bits of an operation.
        send(4'd9, 4'd3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result",    {27'd0, result},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'd1, 4'd2, 1'b0);
        wait_valid(lat);
        check("post_rst_latency", lat, 32'd4);
        check("post_rst_result", {27'd0, result}, 32'b11111);
        @(posedge clk);
        #1;

`ifdef SERIAL_ADD_MODE_EN
        send(4'd15, 4'd15, 1'b1);
        wait_valid(lat);
        check("add_15_15", {27'd0, result}, 32'b11110);
        @(posedge clk);
        #1;
        send(4'd15, 4'd15, 1'b0);
        wait_valid(lat);
        check("sub_15_15", {27'd0, result}, 32'b00000);
        @(posedge clk);
        #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
